// File: rtl/gmii_tx_monitor.sv
// rtl/gmii_tx_monitor.sv - GMII/MII transmit-path terminator with FCS, length and framing checks
//
// Purpose: receives the MAC's GMII/MII transmit stream, strips preamble/SFD,
// re-emits the frame payload (FCS removed) on an AXI-stream master with no
// backpressure, checks the CRC-32 residue and frame length, and keeps
// saturating good/bad frame counters plus the status of the last frame.
//
// Ports:
//   clk, rst                  tx clock, synchronous active-high reset
//   clk_enable                qualifies every GMII byte / MII nibble sample
//   mii_select                1 = MII nibbles on gmii_txd[3:0], 0 = GMII bytes
//   gmii_txd/tx_en/tx_er      MAC transmit signals
//   m_axis_t*                 payload byte stream; tuser = frame bad on tlast
//   frame_good/bad_count      saturating frame counters
//   last_length, last_fcs     length (FCS included) and FCS field of last frame
//   status_fcs_error          one-cycle pulse on CRC residue mismatch
//   status_framing_error      one-cycle pulse on preamble/SFD error, abort, runt
module gmii_tx_monitor #(
    parameter int MIN_FRAME_LENGTH = 64,
    parameter int MAX_FRAME_LENGTH = 1518,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_enable,
    input  logic                 mii_select,
    input  logic [7:0]           gmii_txd,
    input  logic                 gmii_tx_en,
    input  logic                 gmii_tx_er,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic [CNT_WIDTH-1:0] frame_good_count,
    output logic [CNT_WIDTH-1:0] frame_bad_count,
    output logic [15:0]          last_length,
    output logic [31:0]          last_fcs,
    output logic                 status_fcs_error,
    output logic                 status_framing_error
);

    localparam logic [15:0] MIN_LEN     = 16'(MIN_FRAME_LENGTH);
    localparam logic [15:0] MAX_LEN     = 16'(MAX_FRAME_LENGTH);
    // Residue of a good frame in MSB-first form; the register runs reflected,
    // so it is bit-reversed before the compare.
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREAMBLE,
        S_PAYLOAD,
        S_DROP
    } state_t;

    state_t      state;
    logic        armed;
    logic        nib_phase;
    logic [3:0]  nib_low;
    logic        nib_er;
    logic [3:0]  pre_cnt;
    logic [31:0] crc;
    logic [15:0] len;
    logic        err;
    // Five-byte delay line: slot k is dly[8k +: 8]; slot 0 newest, slot 4 oldest.
    logic [39:0] dly;
    logic [2:0]  fill;

    logic [7:0]  smp_byte;
    logic        smp_er;
    logic        byte_vld;
    logic        frame_end;
    logic        odd_end;
    logic        residue_ok;
    logic        frame_bad;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Byte assembly: a byte is complete on every enabled GMII sample, or on
    // the second enabled nibble in MII mode.
    always_comb begin
        smp_byte  = gmii_txd;
        smp_er    = gmii_tx_er;
        byte_vld  = 1'b0;
        frame_end = 1'b0;
        odd_end   = 1'b0;
        if (clk_enable) begin
            if (!gmii_tx_en) begin
                frame_end = 1'b1;
                odd_end   = mii_select & nib_phase;
            end else if (!mii_select) begin
                byte_vld = 1'b1;
            end else if (nib_phase) begin
                byte_vld = 1'b1;
                smp_byte = {gmii_txd[3:0], nib_low};
                smp_er   = gmii_tx_er | nib_er;
            end
        end
    end

    assign residue_ok = (bit_reverse32(crc) == CRC_RESIDUE);
    assign frame_bad  = !residue_ok || err || odd_end || (len < MIN_LEN) || (len > MAX_LEN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= S_IDLE;
            armed                <= 1'b0;
            nib_phase            <= 1'b0;
            nib_low              <= 4'd0;
            nib_er               <= 1'b0;
            pre_cnt              <= 4'd0;
            crc                  <= 32'hFFFFFFFF;
            len                  <= 16'd0;
            err                  <= 1'b0;
            dly                  <= 40'd0;
            fill                 <= 3'd0;
            m_axis_tdata         <= 8'd0;
            m_axis_tvalid        <= 1'b0;
            m_axis_tlast         <= 1'b0;
            m_axis_tuser         <= 1'b0;
            frame_good_count     <= '0;
            frame_bad_count      <= '0;
            last_length          <= 16'd0;
            last_fcs             <= 32'd0;
            status_fcs_error     <= 1'b0;
            status_framing_error <= 1'b0;
        end else begin
            m_axis_tvalid        <= 1'b0;
            m_axis_tlast         <= 1'b0;
            m_axis_tuser         <= 1'b0;
            status_fcs_error     <= 1'b0;
            status_framing_error <= 1'b0;

            if (clk_enable) begin
                if (!gmii_tx_en) begin
                    nib_phase <= 1'b0;
                    armed     <= 1'b1;
                end else if (mii_select) begin
                    if (!nib_phase) begin
                        nib_low   <= gmii_txd[3:0];
                        nib_er    <= gmii_tx_er;
                        nib_phase <= 1'b1;
                    end else begin
                        nib_phase <= 1'b0;
                    end
                end

                case (state)
                    S_IDLE: begin
                        // Disarmed after reset until tx_en is seen low, so a
                        // reset mid-frame never locks onto payload bytes.
                        if (byte_vld && armed) begin
                            if (smp_byte == 8'h55) begin
                                state   <= S_PREAMBLE;
                                pre_cnt <= 4'd1;
                            end else begin
                                state <= S_DROP;
                            end
                        end
                    end

                    S_PREAMBLE: begin
                        if (frame_end) begin
                            state                <= S_IDLE;
                            status_framing_error <= 1'b1;
                            frame_bad_count      <= sat_inc(frame_bad_count);
                        end else if (byte_vld) begin
                            if (smp_byte == 8'h55) begin
                                if (pre_cnt == 4'd7) begin
                                    state                <= S_DROP;
                                    status_framing_error <= 1'b1;
                                    frame_bad_count      <= sat_inc(frame_bad_count);
                                end else begin
                                    pre_cnt <= pre_cnt + 4'd1;
                                end
                            end else if (smp_byte == 8'hD5) begin
                                state <= S_PAYLOAD;
                                crc   <= 32'hFFFFFFFF;
                                len   <= 16'd0;
                                err   <= 1'b0;
                                fill  <= 3'd0;
                            end else begin
                                state                <= S_DROP;
                                status_framing_error <= 1'b1;
                                frame_bad_count      <= sat_inc(frame_bad_count);
                            end
                        end
                    end

                    S_PAYLOAD: begin
                        if (frame_end) begin
                            state <= S_IDLE;
                            if (len < 16'd5) begin
                                status_framing_error <= 1'b1;
                                frame_bad_count      <= sat_inc(frame_bad_count);
                            end else begin
                                m_axis_tvalid        <= 1'b1;
                                m_axis_tdata         <= dly[39:32];
                                m_axis_tlast         <= 1'b1;
                                m_axis_tuser         <= frame_bad;
                                last_length          <= len;
                                last_fcs             <= {dly[7:0], dly[15:8], dly[23:16], dly[31:24]};
                                status_fcs_error     <= !residue_ok;
                                status_framing_error <= odd_end;
                                if (frame_bad) begin
                                    frame_bad_count <= sat_inc(frame_bad_count);
                                end else begin
                                    frame_good_count <= sat_inc(frame_good_count);
                                end
                            end
                        end else if (byte_vld) begin
                            crc <= crc_byte(crc, smp_byte);
                            len <= (&len) ? len : len + 16'd1;
                            err <= err | smp_er;
                            dly <= {dly[31:0], smp_byte};
                            // The last four bytes held back are the FCS.
                            if (fill == 3'd5) begin
                                m_axis_tvalid <= 1'b1;
                                m_axis_tdata  <= dly[39:32];
                            end else begin
                                fill <= fill + 3'd1;
                            end
                        end
                    end

                    S_DROP: begin
                        if (frame_end) begin
                            state <= S_IDLE;
                        end
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/gmii_tx_monitor.md
Name: gmii_tx_monitor

Overview:
- PHY-side GMII receiver that terminates the MAC transmit path for loopback and self-test.
- Takes the MAC's GMII transmit signals (txd/tx_en/tx_er with clock enable and MII select) in the tx clock domain.
- Strips preamble/SFD, checks FCS and length, and re-emits each frame payload on an AXI-stream master without backpressure.
- Keeps good/bad frame counters and the last frame's status for the debug register bank.

Parameters:
MIN_FRAME_LENGTH, 64, minimum legal length in bytes (after SFD, FCS included)
MAX_FRAME_LENGTH, 1518, maximum legal length in bytes (after SFD, FCS included)
CNT_WIDTH, 16, width of the frame counters

Ports:
clk  in  1  tx clock; all logic is on its rising edge
rst  in  1  synchronous, active-high reset
clk_enable  in  1  qualifies every sample (GMII byte or MII nibble)
mii_select  in  1  1 = MII nibble mode, 0 = GMII byte mode
gmii_txd  in  8  transmit data from the MAC
gmii_tx_en  in  1  transmit enable from the MAC
gmii_tx_er  in  1  transmit error from the MAC
m_axis_tdata  out  8  payload byte
m_axis_tvalid  out  1  byte valid, one-cycle strobe; no tready
m_axis_tlast  out  1  last payload byte
m_axis_tuser  out  1  frame bad; meaningful only with tlast
frame_good_count  out  CNT_WIDTH  count of good frames, saturating
frame_bad_count  out  CNT_WIDTH  count of bad or aborted frames, saturating
last_length  out  16  byte count of the last frame (FCS included)
last_fcs  out  32  received FCS field; first byte on the wire is in [7:0]
status_fcs_error  out  1  one-cycle pulse on FCS mismatch
status_framing_error  out  1  one-cycle pulse on preamble/SFD error, abort, or runt below 5 bytes

Behaviour:
- Reset: every output is 0, the FSM goes to IDLE, counters clear, and the block is disarmed.
- Arming: the block arms only after one enabled sample with gmii_tx_en=0. This means a reset mid-frame never resynchronises onto payload.
- clk_enable=0: all state holds, and m_axis_tvalid and the status pulses are 0 that cycle.
- Byte assembly, GMII mode: one byte per enabled sample.
- Byte assembly, MII mode:
  - gmii_txd[3:0] carries the low nibble first; the byte completes on the second enabled sample.
  - Nibble phase resets whenever tx_en=0.
  - tx_en falling on an odd nibble sets a framing error.
- FSM IDLE: armed, tx_en=1 and byte 0x55 -> PREAMBLE with preamble count = 1. Any other byte -> DROP, with no error flagged.
- FSM PREAMBLE:
  - 0x55 increments the count; a count above 7 -> DROP with a framing error.
  - 0xD5 -> PAYLOAD; this resets the CRC to 0xFFFFFFFF, the length to 0 and the error flag.
  - Any other byte -> DROP with a framing error.
  - tx_en=0 -> IDLE with a framing error.
- FSM PAYLOAD:
  - Each byte updates the CRC-32 (reflected polynomial 0x04C11DB7) and increments the length, which saturates at 0xFFFF.
  - Each byte shifts into a 5-byte delay line. When the line already holds 5 bytes, the oldest byte is emitted with tvalid=1 and tlast=0.
  - tx_er=1 sets the error flag.
- FSM DROP: wait for tx_en=0 -> IDLE.
- End of frame, on the enabled sample with tx_en=0 in PAYLOAD:
  - length < 5: no AXI output; bad count +1; status_framing_error pulses.
  - Otherwise the last data byte (delay-line slot 4) is emitted with tlast=1.
  - Bad = (CRC residue != 0xC704DD7B) | error flag | length < MIN_FRAME_LENGTH | length > MAX_FRAME_LENGTH.
  - m_axis_tuser = bad. The good or bad count increments by 1.
  - last_length and last_fcs (delay-line slots 3..0) update.
  - status_fcs_error pulses on a residue mismatch.
  - FSM -> IDLE.
- Latency: AXI outputs are registered and appear 1 clk after the enabled sample that completes the byte. A back-to-back frame needs only a single tx_en=0 sample between frames.
- Counters: each saturates at all-ones. The good and bad counts never both increment for the same frame.

Test Plan:
- GMII, 7x0x55 + 0xD5 + 60 payload bytes + valid FCS:
  - 60 tvalid strobes; tlast on byte 60 with tuser=0.
  - frame_good_count=1, last_length=64, last_fcs equals the sent FCS.
- Same frame with payload byte 10 flipped:
  - Payload still output; tuser=1 on tlast.
  - status_fcs_error pulses once; frame_bad_count=1.
- MII mode, clk_enable high 1 clk in 10, same frame as nibbles:
  - Output bytes identical to the first scenario.
  - No output when clk_enable=0.
- Preamble 0x55 x3 then 0x12:
  - No AXI output; status_framing_error pulses; frame_bad_count=1.
  - A following valid frame is accepted and counted good.
- Valid-FCS 40-byte frame, then a 64-byte frame with tx_er for one byte:
  - Both frames end with tuser=1; frame_bad_count=2.
  - A 3-byte runt produces no output, a framing pulse and frame_bad_count=3.
- rst pulsed mid-payload while tx_en stays high:
  - Counters read 0; no output until tx_en drops.
  - The next full frame yields a normal good output.
